// File: rtl/vga_sched_pkg.sv
// Shared types for the VGA pattern scheduler and other frame-synchronous blocks.
package vga_sched_pkg;
    typedef enum logic [0:0] {SHOW, BLANK} sched_state_t;
    localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/vga_frame_tick.sv
// One-cycle frame tick on the registered inactive->active vsync transition.
module vga_frame_tick #(
    parameter int VS_ACTIVE_LOW = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_vs,
    output logic o_tick
);
    logic vsReg;
    logic vsPrev;

    // Both stages reset to "inactive" so an active vsync right after reset still ticks.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vsReg  <= 1'b0;
            vsPrev <= 1'b0;
        end else begin
            vsReg  <= i_vs ^ (VS_ACTIVE_LOW != 0);
            vsPrev <= vsReg;
        end
    end

    assign o_tick = vsReg & ~vsPrev;
endmodule

// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous test-pattern sequencer with dwell, manual advance and black-frame insertion.
// Optional: define VGA_SCHED_FRAME_COUNT_EN to add the free-running o_frameCount port.
module vga_pattern_scheduler
    import vga_sched_pkg::*;
#(
    parameter int NUM_PATTERNS       = 4,
    parameter int SEL_W              = 2,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int BLANK_FRAMES       = 2,
    parameter int CNT_W              = 8,
    parameter int VS_ACTIVE_LOW      = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_vs,
    input  logic                   i_nextReq,
    input  logic                   i_hold,
    output logic [SEL_W-1:0]       o_patternSel,
    output logic                   o_blank,
    output logic                   o_nextAck,
`ifdef VGA_SCHED_FRAME_COUNT_EN
    output logic [FRAME_CNT_W-1:0] o_frameCount,
`endif
    output logic                   o_busy
);
    localparam logic [SEL_W-1:0] SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

    sched_state_t     state;
    sched_state_t     stateNext;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] blankCnt;
    logic             reqPend;
    logic             pendNow;
    logic             pendNext;
    logic             doSwitch;
    logic             tick;

    vga_frame_tick #(.VS_ACTIVE_LOW(VS_ACTIVE_LOW)) uTick (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_vs   (i_vs),
        .o_tick (tick)
    );

    // A request arriving in the tick cycle itself is served at that tick.
    always_comb begin
        pendNow   = reqPend | i_nextReq;
        doSwitch  = tick && (state == SHOW) && (pendNow || ((dwell == DWELL_LAST) && !i_hold));
        pendNext  = doSwitch ? 1'b0 : pendNow;
        stateNext = state;
        case (state)
            SHOW:    if (doSwitch && (BLANK_FRAMES > 0)) stateNext = BLANK;
            BLANK:   if (tick && (blankCnt == BLANK_LAST)) stateNext = SHOW;
            default: stateNext = SHOW;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= SHOW;
            dwell        <= '0;
            blankCnt     <= '0;
            reqPend      <= 1'b0;
            o_patternSel <= '0;
            o_blank      <= 1'b0;
            o_nextAck    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state     <= stateNext;
            reqPend   <= pendNext;
            o_blank   <= (stateNext == BLANK);
            o_busy    <= pendNext | (stateNext == BLANK);
            o_nextAck <= doSwitch;
            if (doSwitch) begin
                o_patternSel <= (o_patternSel == SEL_LAST) ? '0 : o_patternSel + 1'b1;
                dwell        <= '0;
                blankCnt     <= '0;
            end else if (tick && (state == SHOW) && !i_hold) begin
                dwell <= dwell + 1'b1;
            end else if (tick && (state == BLANK) && (blankCnt != BLANK_LAST)) begin
                blankCnt <= blankCnt + 1'b1;
            end
        end
    end

`ifdef VGA_SCHED_FRAME_COUNT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)   o_frameCount <= '0;
        else if (tick) o_frameCount <= o_frameCount + 1'b1;
    end
`endif
endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Directed bench for vga_pattern_scheduler with a frame-level reference model checked every cycle.
module tb_vga_pattern_scheduler;
    localparam int NP  = 4;
    localparam int FPP = 3;
    localparam int BF  = 1;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_vs = 1'b1;
    logic        i_nextReq = 1'b0;
    logic        i_hold = 1'b0;
    logic [1:0]  o_patternSel;
    logic        o_blank;
    logic        o_nextAck;
    logic        o_busy;
`ifdef VGA_SCHED_FRAME_COUNT_EN
    logic [15:0] o_frameCount;
`endif

    int nVec = 0;
    int nErr = 0;
    int ackCnt = 0;

    vga_pattern_scheduler #(
        .NUM_PATTERNS(NP), .SEL_W(2), .FRAMES_PER_PATTERN(FPP),
        .BLANK_FRAMES(BF), .CNT_W(8), .VS_ACTIVE_LOW(1)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_vs        (i_vs),
        .i_nextReq   (i_nextReq),
        .i_hold      (i_hold),
        .o_patternSel(o_patternSel),
        .o_blank     (o_blank),
        .o_nextAck   (o_nextAck),
`ifdef VGA_SCHED_FRAME_COUNT_EN
        .o_frameCount(o_frameCount),
`endif
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frames shown / blank frames remaining, updated once per clock.
    int msel = 0, shown = 0, blankLeft = 0;
    bit mblank = 0, mack = 0, mbusy = 0, mpend = 0, s1 = 0, s2 = 0;
    logic [15:0] mframes = 0;

    always @(posedge i_clk or posedge i_reset) begin
        bit tk, pendNow;
        if (i_reset) begin
            msel = 0; shown = 0; blankLeft = 0; mblank = 0; mack = 0;
            mbusy = 0; mpend = 0; s1 = 0; s2 = 0; mframes = 0;
        end else begin
            tk = s1 && !s2;
            s2 = s1;
            s1 = (i_vs == 1'b0);
            pendNow = mpend || i_nextReq;
            mack = 0;
            if (tk) mframes = mframes + 16'd1;
            if (tk && !mblank && (pendNow || (!i_hold && shown + 1 >= FPP))) begin
                msel = (msel + 1) % NP;
                shown = 0;
                mpend = 0;
                mack = 1;
                if (BF > 0) begin
                    mblank = 1;
                    blankLeft = BF;
                end
            end else begin
                mpend = pendNow;
                if (tk) begin
                    if (mblank) begin
                        blankLeft--;
                        if (blankLeft == 0) mblank = 0;
                    end else if (!i_hold) begin
                        shown++;
                    end
                end
            end
            mbusy = mpend || mblank;
        end
    end

    always @(negedge i_clk) begin
        chk("sel", 32'(o_patternSel), 32'(msel));
        chk("blank", 32'(o_blank), 32'(mblank));
        chk("ack", 32'(o_nextAck), 32'(mack));
        chk("busy", 32'(o_busy), 32'(mbusy));
`ifdef VGA_SCHED_FRAME_COUNT_EN
        chk("frameCount", 32'(o_frameCount), 32'(mframes));
`endif
        if (o_nextAck === 1'b1) ackCnt++;
    end

    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    // One 10-cycle frame; vsync active (low) for two samples, tick early in the frame.
    task automatic frame(input bit reqTick, input bit reqMid);
        step(); i_vs = 1'b0;
        step(); if (reqTick) i_nextReq = 1'b1;
        step(); i_nextReq = 1'b0; i_vs = 1'b1;
        step();
        step(); if (reqMid) i_nextReq = 1'b1;
        step(); i_nextReq = 1'b0;
        if (reqMid) chk("busyAfterReq", 32'(o_busy), 32'd1);
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame(1'b0, 1'b0);
    endtask

    initial begin
        #1 i_reset = 1'b1;
        step(); step();
        chk("rstSel", 32'(o_patternSel), 32'd0);
        chk("rstBlank", 32'(o_blank), 32'd0);
        chk("rstBusy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;
        step();

        // Auto-advance
        frames(2);
        chk("t2Sel", 32'(o_patternSel), 32'd0);
        frames(1);
        chk("t3Sel", 32'(o_patternSel), 32'd1);
        chk("t3Blank", 32'(o_blank), 32'd1);
        chk("t3Model", 32'(msel), 32'd1);
        frames(1);
        chk("t4Blank", 32'(o_blank), 32'd0);
        frames(3);
        chk("t7Sel", 32'(o_patternSel), 32'd2);
        frames(4);
        chk("t11Sel", 32'(o_patternSel), 32'd3);
        chk("t11Acks", 32'(ackCnt), 32'd3);

        // Wrap on a mid-frame request
        frame(1'b0, 1'b1);
        chk("t12Sel", 32'(o_patternSel), 32'd3);
        frame(1'b0, 1'b0);
        chk("wrapSel", 32'(o_patternSel), 32'd0);
        chk("wrapAcks", 32'(ackCnt), 32'd4);

        // Request in the tick cycle, then a request latched during BLANK
        frame(1'b0, 1'b0);
        frame(1'b1, 1'b1);
        chk("tickReqSel", 32'(o_patternSel), 32'd1);
        chk("tickReqBlank", 32'(o_blank), 32'd1);
        frame(1'b0, 1'b0);
        chk("blankReqSel", 32'(o_patternSel), 32'd1);
        chk("blankReqBlank", 32'(o_blank), 32'd0);
        chk("blankReqBusy", 32'(o_busy), 32'd1);
        frame(1'b0, 1'b0);
        chk("blankReqServed", 32'(o_patternSel), 32'd2);
        chk("blankReqModel", 32'(msel), 32'd2);
        frame(1'b0, 1'b0);

        // Hold freezes dwell
        i_hold = 1'b1;
        frames(10);
        chk("holdSel", 32'(o_patternSel), 32'd2);
        chk("holdAcks", 32'(ackCnt), 32'd6);
        i_hold = 1'b0;
        frames(2);
        chk("rel2Sel", 32'(o_patternSel), 32'd2);
        frames(1);
        chk("rel3Sel", 32'(o_patternSel), 32'd3);
        frame(1'b0, 1'b0);
        i_hold = 1'b1;
        frame(1'b0, 1'b1);
        frame(1'b0, 1'b0);
        chk("holdReqSel", 32'(o_patternSel), 32'd0);
        i_hold = 1'b0;

        // Reset asserted mid-BLANK, between clock edges
        frame(1'b0, 1'b0);
        frame(1'b0, 1'b1);
        frame(1'b0, 1'b1);
        chk("preRstSel", 32'(o_patternSel), 32'd1);
        chk("preRstBlank", 32'(o_blank), 32'd1);
        @(posedge i_clk);
        #3 i_reset = 1'b1;
        #1;
        chk("asyncSel", 32'(o_patternSel), 32'd0);
        chk("asyncBlank", 32'(o_blank), 32'd0);
        chk("asyncBusy", 32'(o_busy), 32'd0);
        chk("asyncAck", 32'(o_nextAck), 32'd0);
        step();
        i_reset = 1'b0;
`ifdef VGA_SCHED_FRAME_COUNT_EN
        chk("fcReset", 32'(o_frameCount), 32'd0);
`endif
        frames(5);
`ifdef VGA_SCHED_FRAME_COUNT_EN
        chk("fcFive", 32'(o_frameCount), 32'd5);
`endif
        chk("postRstSel", 32'(o_patternSel), 32'd1);
        chk("postRstBlank", 32'(o_blank), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
